// File: rtl/shift_register_pkg.sv
// Shared constants and next-state select encoding for the right-shift register.
package shift_register_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 5;
    localparam logic [31:0] DEFAULT_RESET_VALUE = 32'd0;

    typedef enum logic [1:0] {
        Clear  = 2'd0,
        Load   = 2'd1,
        Shift  = 2'd2,
        Rotate = 2'd3
    } sel_e;

    // Priority: clear beats load beats rotate beats plain shift.
    function automatic sel_e select_next(input logic clear, input logic load,
                                         input logic rotate);
        if (clear) begin
            return Clear;
        end else if (load) begin
            return Load;
        end else if (rotate) begin
            return Rotate;
        end
        return Shift;
    endfunction

endpackage

// File: rtl/shift_register_cell.sv
// One register bit: synchronous D flip-flop with a clear/load/shift/rotate data mux.
module shift_register_cell
    import shift_register_pkg::*;
(
    input  logic clockpulse,
    input  sel_e sel,
    input  logic clear_bit,
    input  logic load_bit,
    input  logic shift_bit,
    input  logic rotate_bit,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clockpulse) begin
        unique case (sel)
            Clear:  q <= clear_bit;
            Load:   q <= load_bit;
            Shift:  q <= shift_bit;
            Rotate: q <= rotate_bit;
        endcase
    end

    assign qbar = ~q;

endmodule

// File: rtl/shift_register_6bit_right.sv
// Right-shift register built from a chain of shift_register_cell instances.
// Define SHIFTREG_ROTATE_EN to add the rotate input (MSB takes out[0] instead of serialInput).
module shift_register_6bit_right
    import shift_register_pkg::*;
#(
    parameter int unsigned     WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             serialInput,
    input  logic             enablePreset,
    input  logic [WIDTH-1:0] preset,
`ifdef SHIFTREG_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] notout
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("shift_register_6bit_right: WIDTH must be within 2..32");
    end

    logic rotate_req;
    sel_e sel;

`ifdef SHIFTREG_ROTATE_EN
    assign rotate_req = rotate;
`else
    assign rotate_req = 1'b0;
`endif

    always_comb begin
        sel = Shift;
        sel = select_next(clear, enablePreset, rotate_req);
    end

    // Every cell sees the same select; only the MSB's shift/rotate sources differ.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic shift_src;
        logic rotate_src;

        if (i == WIDTH - 1) begin : g_msb
            assign shift_src  = serialInput;
            assign rotate_src = out[0];
        end else begin : g_low
            assign shift_src  = out[i+1];
            assign rotate_src = out[i+1];
        end

        shift_register_cell u_cell (
            .clockpulse (clockpulse),
            .sel        (sel),
            .clear_bit  (RESET_VALUE[i]),
            .load_bit   (preset[i]),
            .shift_bit  (shift_src),
            .rotate_bit (rotate_src),
            .q          (out[i]),
            .qbar       (notout[i])
        );
    end

endmodule

// File: tb/tb_shift_register_6bit_right.sv
// Scoreboard bench for shift_register_6bit_right; rotate stimulus is added when
// SHIFTREG_ROTATE_EN is defined.
module tb_shift_register_6bit_right;

    localparam int W = 5;
    localparam logic [W-1:0] RV = '0;

    logic         clockpulse = 1'b0;
    logic         clear = 1'b0;
    logic         serialInput = 1'b0;
    logic         enablePreset = 1'b0;
    logic [W-1:0] preset = '0;
    logic [W-1:0] out;
    logic [W-1:0] notout;
`ifdef SHIFTREG_ROTATE_EN
    logic         rotate = 1'b0;
`endif

    shift_register_6bit_right #(
        .WIDTH       (W),
        .RESET_VALUE (RV)
    ) dut (
        .clockpulse   (clockpulse),
        .clear        (clear),
        .serialInput  (serialInput),
        .enablePreset (enablePreset),
        .preset       (preset),
`ifdef SHIFTREG_ROTATE_EN
        .rotate       (rotate),
`endif
        .out          (out),
        .notout       (notout)
    );

    always #5 clockpulse = ~clockpulse;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int unsigned  model;  // behavioural value of the register, as an integer

    // Drive one edge's inputs and push the value the register must hold after it.
    task automatic step(input logic clr, input logic ep, input logic [W-1:0] pre,
                        input logic sin, input logic rot, input string nm);
        int unsigned top;
        @(negedge clockpulse);
        clear        = clr;
        enablePreset = ep;
        preset       = pre;
        serialInput  = sin;
`ifdef SHIFTREG_ROTATE_EN
        rotate       = rot;
`else
        rot          = 1'b0;
`endif
        if (clr) begin
            model = int'(RV);
        end else if (ep) begin
            model = int'(pre);
        end else begin
            top   = rot ? (model % 2) : int'(sin);
            model = (model / 2) + top * (2 ** (W - 1));
        end
        exp_q.push_back(W'(model));
        name_q.push_back(nm);
    endtask

    // Monitor: the register presents a new value after every edge.
    logic [W-1:0] e;
    string        n;
    always @(posedge clockpulse) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests++;
            if (out !== e) begin
                fails++;
                $display("FAIL %s out: got %b expected %b", n, out, e);
            end
            tests++;
            if (notout !== ~e) begin
                fails++;
                $display("FAIL %s notout: got %b expected %b", n, notout, ~e);
            end
        end
    end

    initial begin
        model = 0;
        repeat (2) @(posedge clockpulse);

        step(1, 0, 5'b00000, 0, 0, "clear");
        step(1, 1, 5'b10101, 1, 0, "clear_over_preset");

        step(0, 1, 5'b00011, 0, 0, "preset_00011");
        for (int i = 0; i < 14; i++) step(0, 0, 5'b11111, 0, 0, "shift_zero");

        for (int i = 0; i < 5; i++) step(0, 0, 5'b00000, 1, 0, "shift_one");

        step(0, 1, 5'b10110, 0, 0, "preset_10110");
        step(0, 0, 5'b00000, 0, 0, "shift_after_preset");
        step(1, 0, 5'b00000, 1, 0, "clear_midstream");

`ifdef SHIFTREG_ROTATE_EN
        step(0, 1, 5'b00011, 1, 1, "rot_preset_priority");
        for (int i = 0; i < 3; i++) step(0, 0, 5'b00000, 0, 1, "rotate");
`endif

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(15) == 0), ($urandom_range(7) == 0),
                 W'($urandom), 1'($urandom), 1'($urandom), "random");
        end

        @(negedge clockpulse);
        @(negedge clockpulse);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_register_6bit_right.md
SHIFT_REGISTER_6BIT_RIGHT -- requirements
Module: shift_register_6bit_right

Interface
REQ-001 Parameter: WIDTH, 5, register width in bits; legal range 2 to 32.
REQ-002 Parameter: RESET_VALUE, 0, register contents after clear.
REQ-003 Port: clockpulse  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: clear  input  1  reset; synchronous and active-high.
REQ-005 Port: serialInput  input  1  bit shifted into the MSB (out[WIDTH-1]) on each shift.
REQ-006 Port: enablePreset  input  1  parallel-load enable, sampled at the rising edge.
REQ-007 Port: preset  input  WIDTH  parallel-load value; narrower drivers are zero-extended by the parent.
REQ-008 Port: out  output  WIDTH  current register contents (Q).
REQ-009 Port: notout  output  WIDTH  bitwise complement of out (Q-bar); it is never stored separately.

Function
REQ-010 The block SHALL update state only on the rising clockpulse edge; there are no asynchronous paths except notout = ~out.
REQ-011 Priority per edge SHALL be: clear, then enablePreset, then shift.
REQ-012 clear=1 SHALL load RESET_VALUE regardless of the other inputs.
REQ-013 enablePreset=1 with clear=0 SHALL load out <= preset in the same edge, with a latency of 1 cycle and no shift that cycle.
REQ-014 Otherwise the block SHALL shift right every edge: out[i] <= out[i+1] for i < WIDTH-1, and out[WIDTH-1] <= serialInput; out[0] is discarded.
REQ-015 There is no hold mode; with no load and no clear, a shift SHALL occur every edge.
REQ-016 After WIDTH consecutive shifts with serialInput=0, out SHALL be all-zero and SHALL remain so.
REQ-017 A preset asserted together with clear SHALL be ignored, and the clear value SHALL be applied.
REQ-018 notout SHALL be exactly ~out in every cycle, including reset.

Reset
REQ-019 Before the first clear edge, out is undefined (X in simulation); no initial value is relied upon.
REQ-020 After a clear edge, out SHALL equal RESET_VALUE (0) and notout SHALL equal all ones.
REQ-021 A clear asserted mid-stream SHALL abort the shift in that edge and take effect at the edge.

Configuration
REQ-022 Macro SHIFTREG_ROTATE_EN: when defined, the block SHALL add input port rotate (1 bit).
REQ-023 With SHIFTREG_ROTATE_EN defined and rotate=1, the MSB SHALL receive out[0] instead of serialInput (rotate right); rotate has lower priority than clear and preset.
REQ-024 Without SHIFTREG_ROTATE_EN, the rotate port SHALL be absent and behaviour SHALL be exactly REQ-014.

Structure
REQ-025 Package shift_register_pkg SHALL hold the constants DEFAULT_WIDTH=5 and DEFAULT_RESET_VALUE=0, plus a typedef for the next-state select encoding (CLEAR, LOAD, SHIFT, ROTATE).
REQ-026 One sub-module, shift_register_cell, SHALL implement a single D flip-flop with synchronous clear/load/data-mux and Q/Q-bar outputs; the top SHALL instantiate WIDTH cells via generate and chain them.

Verification
REQ-027 clear=1, one edge -> out=00000, notout=11111.
REQ-028 clear=0, enablePreset=1, preset=00011, one edge; then enablePreset=0, serialInput=0 -> out sequence 00011, 00001, 00000, 00000 (steady for the remaining 12 edges of a 15-edge run).
REQ-029 out=00000, serialInput=1 for 5 edges -> 10000, 11000, 11100, 11110, 11111.
REQ-030 clear=1 and enablePreset=1 (preset=10101) in the same edge -> out=00000.
REQ-031 Preset 10110, then clear asserted on the 2nd shift edge -> 01011, then 00000.
REQ-032 With SHIFTREG_ROTATE_EN defined: preset 00011, rotate=1 -> 10001, 11000, 01100.
